// File: rtl/i2c_mst_wr_stream.sv
// I2C master write engine: START, addr+W, ACK-checked data bytes pulled from a ready/valid stream, STOP.
// Optional macro I2C_MST_CLK_STRETCH_EN: freeze quarter timing while a slave holds released SCL low.
module i2c_mst_wr_stream #(
    parameter int CLK_DIV = 125,
    parameter int CNT_W   = 16
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             start_i,
    input  logic [6:0]       slv_addr_i,
    input  logic [7:0]       data_i,
    input  logic             data_valid_i,
    input  logic             data_last_i,
    output logic             data_ready_o,
    input  logic             scl_i,
    input  logic             sda_i,
    output logic             scl_oe_o,
    output logic             sda_oe_o,
    output logic             busy_o,
    output logic             done_o,
    output logic             nack_o,
    output logic [CNT_W-1:0] byte_cnt_o
);
    localparam int DIV_W = $clog2(CLK_DIV);
    localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(CLK_DIV - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_START, S_ADDR, S_ACK, S_LOAD, S_DATA, S_STOP, S_DONE
    } state_t;

    state_t           state_reg, state_next;
    logic [DIV_W-1:0] div_cnt_reg, div_cnt_next;
    logic [1:0]       q_reg, q_next;
    logic [2:0]       bit_cnt_reg, bit_cnt_next;
    logic [7:0]       sh_reg, sh_next;
    logic             last_reg, last_next;
    logic             data_phase_reg, data_phase_next;
    logic             nack_reg, nack_next;
    logic [CNT_W-1:0] byte_cnt_reg, byte_cnt_next;
    logic             scl_oe_reg, sda_pipe_reg, sda_oe_reg;
    logic             scl_d, sda_d;
    logic             hold, tick;

`ifdef I2C_MST_CLK_STRETCH_EN
    assign hold = (state_reg != S_IDLE) && !scl_oe_reg && !scl_i;
`else
    logic unused_scl;
    assign unused_scl = scl_i;
    assign hold       = 1'b0;
`endif

    assign tick = (div_cnt_reg == DIV_MAX) && !hold;

    always_comb begin
        state_next      = state_reg;
        div_cnt_next    = div_cnt_reg;
        q_next          = q_reg;
        bit_cnt_next    = bit_cnt_reg;
        sh_next         = sh_reg;
        last_next       = last_reg;
        data_phase_next = data_phase_reg;
        nack_next       = nack_reg;
        byte_cnt_next   = byte_cnt_reg;

        // LOAD parks the divider so the first DATA quarter is full length
        if (state_reg == S_IDLE || state_reg == S_LOAD || state_reg == S_DONE)
            div_cnt_next = '0;
        else if (tick)
            div_cnt_next = '0;
        else if (!hold)
            div_cnt_next = div_cnt_reg + DIV_W'(1);

        case (state_reg)
            S_IDLE: begin
                if (start_i) begin
                    state_next      = S_START;
                    q_next          = 2'd0;
                    bit_cnt_next    = 3'd0;
                    sh_next         = {slv_addr_i, 1'b0};
                    data_phase_next = 1'b0;
                    nack_next       = 1'b0;
                    byte_cnt_next   = '0;
                end
            end
            S_START: begin
                if (tick) begin
                    q_next = q_reg + 2'd1;
                    if (q_reg == 2'd2) begin
                        state_next = S_ADDR;
                        q_next     = 2'd0;
                    end
                end
            end
            S_ADDR, S_DATA: begin
                if (tick) begin
                    q_next = q_reg + 2'd1;
                    if (q_reg == 2'd3) begin
                        sh_next      = {sh_reg[6:0], 1'b0};
                        bit_cnt_next = bit_cnt_reg + 3'd1;
                        if (bit_cnt_reg == 3'd7)
                            state_next = S_ACK;
                    end
                end
            end
            S_ACK: begin
                if (tick) begin
                    q_next = q_reg + 2'd1;
                    if (q_reg == 2'd3) begin
                        if (sda_i) begin
                            nack_next  = 1'b1;
                            state_next = S_STOP;
                        end else if (data_phase_reg) begin
                            if (byte_cnt_reg != {CNT_W{1'b1}})
                                byte_cnt_next = byte_cnt_reg + CNT_W'(1);
                            state_next = last_reg ? S_STOP : S_LOAD;
                        end else begin
                            state_next = S_LOAD;
                        end
                    end
                end
            end
            S_LOAD: begin
                if (data_valid_i) begin
                    sh_next         = data_i;
                    last_next       = data_last_i;
                    data_phase_next = 1'b1;
                    bit_cnt_next    = 3'd0;
                    q_next          = 2'd0;
                    state_next      = S_DATA;
                end
            end
            S_STOP: begin
                if (tick) begin
                    q_next = q_reg + 2'd1;
                    if (q_reg == 2'd2) begin
                        state_next = S_DONE;
                        q_next     = 2'd0;
                    end
                end
            end
            S_DONE:  state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    always_comb begin
        scl_d = 1'b0;
        sda_d = 1'b0;
        case (state_reg)
            S_START: sda_d = (q_reg != 2'd0);
            S_ADDR, S_DATA: begin
                scl_d = ~q_reg[1];
                sda_d = ~sh_reg[7];
            end
            S_ACK:  scl_d = ~q_reg[1];
            S_LOAD: scl_d = 1'b1;
            S_STOP: begin
                scl_d = (q_reg == 2'd0);
                sda_d = (q_reg != 2'd2);
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_reg      <= S_IDLE;
            div_cnt_reg    <= '0;
            q_reg          <= 2'd0;
            bit_cnt_reg    <= 3'd0;
            sh_reg         <= 8'h00;
            last_reg       <= 1'b0;
            data_phase_reg <= 1'b0;
            nack_reg       <= 1'b0;
            byte_cnt_reg   <= '0;
            scl_oe_reg     <= 1'b0;
            sda_pipe_reg   <= 1'b0;
            sda_oe_reg     <= 1'b0;
        end else begin
            state_reg      <= state_next;
            div_cnt_reg    <= div_cnt_next;
            q_reg          <= q_next;
            bit_cnt_reg    <= bit_cnt_next;
            sh_reg         <= sh_next;
            last_reg       <= last_next;
            data_phase_reg <= data_phase_next;
            nack_reg       <= nack_next;
            byte_cnt_reg   <= byte_cnt_next;
            scl_oe_reg     <= scl_d;
            // SDA trails SCL by an extra clock so data never moves while SCL is still high
            sda_pipe_reg   <= sda_d;
            sda_oe_reg     <= sda_pipe_reg;
        end
    end

    assign scl_oe_o     = scl_oe_reg;
    assign sda_oe_o     = sda_oe_reg;
    assign data_ready_o = (state_reg == S_LOAD);
    assign busy_o       = (state_reg != S_IDLE);
    assign done_o       = (state_reg == S_DONE);
    assign nack_o       = nack_reg;
    assign byte_cnt_o   = byte_cnt_reg;

endmodule

// File: tb/tb_i2c_mst_wr_stream.sv
// Bench for i2c_mst_wr_stream: open-drain bus, byte-capturing slave model feeding a scoreboard.
`timescale 1ns/1ps
module tb_i2c_mst_wr_stream;
    localparam int CLK_DIV = 4;
    localparam int CNT_W   = 16;
    localparam int FRAME   = 4 * CLK_DIV;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             start;
    logic [6:0]       slv_addr;
    logic [7:0]       data;
    logic             data_valid;
    logic             data_last;
    logic             data_ready;
    logic             scl_oe, sda_oe;
    logic             busy, done, nack;
    logic [CNT_W-1:0] byte_cnt;

    logic slv_sda_pull = 1'b0;
    logic slv_scl_hold = 1'b0;
    logic scl_line, sda_line;
    assign scl_line = ~scl_oe & ~slv_scl_hold;
    assign sda_line = ~sda_oe & ~slv_sda_pull;

    always #5 clk = ~clk;

    i2c_mst_wr_stream #(.CLK_DIV(CLK_DIV), .CNT_W(CNT_W)) dut (
        .clk_i(clk), .rst_ni(rst_n), .start_i(start), .slv_addr_i(slv_addr),
        .data_i(data), .data_valid_i(data_valid), .data_last_i(data_last),
        .data_ready_o(data_ready), .scl_i(scl_line), .sda_i(sda_line),
        .scl_oe_o(scl_oe), .sda_oe_o(sda_oe), .busy_o(busy), .done_o(done),
        .nack_o(nack), .byte_cnt_o(byte_cnt)
    );

    int n_cmp = 0;
    int n_fail = 0;
    logic [7:0] exp_q[$];
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic timeout_fail(input string name);
        n_cmp++;
        n_fail++;
        $display("FAIL %s: timed out waiting on DUT", name);
    endtask

    // Slave model / monitor: captures bytes on SCL rise, ACKs unless byte index == nack_at
    logic prev_scl = 1'b1, prev_sda = 1'b1;
    int bitn = 0, byte_idx = 0, nack_at = -1, stop_cnt = 0, done_cnt = 0;
    logic [7:0] shift = 8'h00;
    always @(negedge clk) begin
        if (!rst_n) begin
            bitn = 0;
            byte_idx = 0;
            slv_sda_pull = 1'b0;
        end else begin
            if (prev_scl && scl_line && prev_sda && !sda_line) begin
                bitn = 0;
                byte_idx = 0;
            end else if (prev_scl && scl_line && !prev_sda && sda_line) begin
                stop_cnt++;
                bitn = 0;
            end else if (!prev_scl && scl_line) begin
                if (bitn < 8) begin
                    shift = {shift[6:0], sda_line};
                    bitn++;
                    if (bitn == 8) begin
                        if (exp_q.size() == 0) begin
                            n_cmp++;
                            n_fail++;
                            $display("FAIL bus_byte: got 0x%02h expected nothing", shift);
                        end else begin
                            chk("bus_byte", {24'h0, shift}, {24'h0, exp_q.pop_front()});
                        end
                    end
                end else begin
                    bitn = 9;
                end
            end else if (prev_scl && !scl_line) begin
                if (bitn == 8) begin
                    slv_sda_pull = (byte_idx != nack_at);
                end else if (bitn == 9) begin
                    slv_sda_pull = 1'b0;
                    bitn = 0;
                    byte_idx++;
                end
            end
            if (done) done_cnt++;
        end
        prev_scl = scl_line;
        prev_sda = sda_line;
    end

    task automatic pulse_start(input logic [6:0] a);
        @(negedge clk);
        slv_addr = a;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        slv_addr = 7'h00;
    endtask

    task automatic xfer(input logic [6:0] a, input int nbytes,
                        input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2,
                        input int nk, input int stall, input bit measure, input bit poke,
                        input int exp_fed, input logic exp_nack, input int exp_cnt);
        logic [7:0] dat [3];
        int fed, d0c, s0c, w, viol, t0, t1;
        bit fin;
        dat[0] = b0; dat[1] = b1; dat[2] = b2;
        fed = 0; d0c = done_cnt; s0c = stop_cnt; fin = 1'b0;
        nack_at = nk;
        exp_q.push_back({a, 1'b0});
        for (int i = 0; i < nbytes; i++)
            if (nk < 0 || i + 1 <= nk) exp_q.push_back(dat[i]);
        pulse_start(a);
        chk("busy_after_start", {31'h0, busy}, 32'd1);
        chk("nack_cleared", {31'h0, nack}, 32'd0);
        chk("cnt_cleared", {16'h0, byte_cnt}, 32'd0);
        while (!fin) begin
            w = 0;
            while (!data_ready && done_cnt == d0c && w < 5000) begin
                @(negedge clk);
                w++;
            end
            if (w >= 5000) begin
                timeout_fail("wait_ready_or_done");
                fin = 1'b1;
            end else if (done_cnt != d0c) begin
                fin = 1'b1;
            end else begin
                if (fed == 0 && stall > 0) begin
                    viol = 0;
                    repeat (3) @(negedge clk);
                    for (int c = 0; c < stall; c++) begin
                        if (!scl_oe || !data_ready || sda_oe) viol++;
                        @(negedge clk);
                    end
                    chk("stall_hold_violations", viol, 32'd0);
                end
                data = (fed < nbytes) ? dat[fed] : 8'h00;
                data_last = (fed >= nbytes - 1);
                data_valid = 1'b1;
                @(negedge clk);
                data_valid = 1'b0;
                data = 8'h00;
                data_last = 1'b0;
                fed++;
                chk("ready_drop", {31'h0, data_ready}, 32'd0);
                if (poke && fed == 1) pulse_start(7'h01);
                if (measure && fed == 1) begin
                    w = 0;
                    while (!scl_line && w < 1000) begin @(negedge clk); w++; end
                    while (scl_oe == 1'b0 && w < 1000) begin @(negedge clk); w++; end
                    if (!scl_oe) @(negedge clk);
                    while (!scl_oe && w < 1000) begin @(negedge clk); w++; end
                    t0 = cyc;
`ifdef I2C_MST_CLK_STRETCH_EN
                    slv_scl_hold = 1'b1;
                    while (scl_oe && w < 1000) begin @(negedge clk); w++; end
                    repeat (50) @(negedge clk);
                    slv_scl_hold = 1'b0;
`endif
                    while (scl_oe && w < 1000) begin @(negedge clk); w++; end
                    while (!scl_oe && w < 1000) begin @(negedge clk); w++; end
                    t1 = cyc;
                    if (w >= 1000) timeout_fail("frame_measure");
`ifdef I2C_MST_CLK_STRETCH_EN
                    chk("frame_len", t1 - t0, FRAME + 50);
`else
                    chk("frame_len", t1 - t0, FRAME);
`endif
                end
            end
        end
        repeat (3) @(negedge clk);
        chk("bytes_requested", fed, exp_fed);
        chk("nack", {31'h0, nack}, {31'h0, exp_nack});
        chk("byte_cnt", {16'h0, byte_cnt}, exp_cnt);
        chk("done_pulses", done_cnt - d0c, 32'd1);
        chk("stop_seen", stop_cnt - s0c, 32'd1);
        chk("busy_idle", {31'h0, busy}, 32'd0);
        chk("scoreboard_drained", exp_q.size(), 32'd0);
        exp_q.delete();
        $display("txn addr=0x%02h requested=%0d nack=%0b byte_cnt=%0d", a, fed, nack, byte_cnt);
    endtask

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int w;
        rst_n = 1'b0; start = 1'b0; slv_addr = 7'h00;
        data = 8'h00; data_valid = 1'b0; data_last = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_scl_oe", {31'h0, scl_oe}, 32'd0);
        chk("rst_sda_oe", {31'h0, sda_oe}, 32'd0);
        chk("rst_ready", {31'h0, data_ready}, 32'd0);
        chk("rst_busy", {31'h0, busy}, 32'd0);
        chk("rst_done", {31'h0, done}, 32'd0);
        chk("rst_nack", {31'h0, nack}, 32'd0);
        chk("rst_byte_cnt", {16'h0, byte_cnt}, 32'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // two-byte stream, all ACKed, a start during busy must be ignored
        xfer(7'h3A, 2, 8'hA5, 8'h5A, 8'h00, -1, 0, 1'b0, 1'b1, 2, 1'b0, 2);
        // address NACK
        xfer(7'h50, 1, 8'h99, 8'h00, 8'h00, 0, 0, 1'b0, 1'b0, 0, 1'b1, 0);
        // second data byte NACKed
        xfer(7'h21, 3, 8'h11, 8'h22, 8'h33, 2, 0, 1'b0, 1'b0, 2, 1'b1, 1);
        // valid withheld 200 cycles in LOAD
        xfer(7'h2C, 2, 8'hC3, 8'h3C, 8'h00, -1, 200, 1'b0, 1'b0, 2, 1'b0, 2);

        // reset in the middle of a data byte
        nack_at = -1;
        exp_q.push_back({7'h12, 1'b0});
        pulse_start(7'h12);
        w = 0;
        while (!data_ready && w < 5000) begin @(negedge clk); w++; end
        data = 8'h0F; data_last = 1'b1; data_valid = 1'b1;
        @(negedge clk);
        data_valid = 1'b0; data_last = 1'b0;
        while (!(byte_idx == 1 && bitn == 3 && scl_oe && sda_oe) && w < 5000) begin
            @(negedge clk);
            w++;
        end
        if (w >= 5000) timeout_fail("wait_mid_data");
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_scl_oe", {31'h0, scl_oe}, 32'd0);
        chk("async_rst_sda_oe", {31'h0, sda_oe}, 32'd0);
        chk("async_rst_busy", {31'h0, busy}, 32'd0);
        chk("async_rst_ready", {31'h0, data_ready}, 32'd0);
        chk("abort_scoreboard", exp_q.size(), 32'd0);
        exp_q.delete();
        $display("txn addr=0x12 aborted by reset");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // clean transaction after reset
        xfer(7'h7F, 1, 8'h80, 8'h00, 8'h00, -1, 0, 1'b0, 1'b0, 1, 1'b0, 1);
        // frame timing, with slave clock stretch when the feature is built in
        xfer(7'h35, 1, 8'h96, 8'h00, 8'h00, -1, 0, 1'b1, 1'b0, 1, 1'b0, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
